// File: rtl/txd_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit frame transmitter among NCH requesters.
// Define TXD_ARB_TIMEOUT_EN to enable the frame watchdog and the sticky err flag.
module txd_arbiter #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [32*NCH-1:0] req_data,
  output logic [NCH-1:0]    ack,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              txd_start,
  output logic [31:0]       txd_data,
  input  logic              txd_ready,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  state_t         state;
  logic [2:0]     rr_ptr;
  logic           found;
  logic [2:0]     win_id;
  logic [31:0]    win_data;
  logic [NCH-1:0] ack_vec;

  // Scan requests starting at rr_ptr and wrapping modulo NCH; first hit wins.
  always_comb begin
    logic [NCH-1:0] rot;
    int unsigned    j;
    found = 1'b0;
    win_id = '0;
    rot = '0;
    j = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= NCH) j = j - NCH;
      rot = req >> j;
      if (!found && rot[0]) begin
        found = 1'b1;
        win_id = 3'(j);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (win_id == 3'(k)) win_data = req_data[32*k +: 32];
    end
  end

  assign ack_vec = {{(NCH-1){1'b0}}, 1'b1} << grant_id;

`ifdef TXD_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = err_clr | (TIMEOUT_CYC == 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack       <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      txd_start <= 1'b0;
      txd_data  <= '0;
`ifdef TXD_ARB_TIMEOUT_EN
      err       <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      txd_start <= 1'b0;
      ack       <= '0;
`ifdef TXD_ARB_TIMEOUT_EN
      if (err_clr) err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (txd_ready && found) begin
            txd_data  <= win_data;
            grant_id  <= win_id;
            busy      <= 1'b1;
            txd_start <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_BUSY;
`ifdef TXD_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT_BUSY, WAIT_DONE: begin
`ifdef TXD_ARB_TIMEOUT_EN
          // Watchdog expiry takes priority; the normal wait logic below is its else-branch.
          wd_cnt <= wd_cnt + 32'd1;
          if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
            err   <= 1'b1;
            ack   <= ack_vec;
            state <= ACK;
          end else
`endif
          if (state == WAIT_BUSY) begin
            if (!txd_ready) state <= WAIT_DONE;
          end else if (txd_ready) begin
            ack   <= ack_vec;
            state <= ACK;
          end
        end
        ACK: begin
          busy   <= 1'b0;
          rr_ptr <= (grant_id == 3'(NCH - 1)) ? 3'd0 : grant_id + 3'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
